// File: rtl/demortl_arb_pkg.sv
// Shared definitions for the demortl arbiters.
// State encoding and a generic round-robin pick helper.
package demortl_arb_pkg;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] READ = 1'b1;

  localparam int unsigned MAX_SRC = 32;
  localparam int unsigned MAX_W   = 5;

  // Scanning a zero-padded 32-bit mask modulo 32 gives the same winner
  // as scanning the real mask modulo its own size.
  function automatic logic [MAX_W-1:0] rr_pick(
    input logic [MAX_SRC-1:0] eligible,
    input logic [MAX_W-1:0]   ptr
  );
    logic [MAX_W-1:0] idx;
    logic [MAX_W-1:0] j;
    logic             hit;
    idx = '0;
    hit = 1'b0;
    for (int k = 0; k < MAX_SRC; k++) begin
      j = ptr + MAX_W'(k);
      if (!hit && eligible[j]) begin
        hit = 1'b1;
        idx = j;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Rotating priority encoder: first set request at or after ptr_i,
// wrapping modulo N.
module rr_priority_pick #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic         found_o,
  output logic [W-1:0] idx_o
);

  logic [N-1:0] rot;
  logic [W-1:0] off;

  function automatic logic [W-1:0] wrap(input int unsigned v);
    int unsigned r;
    r = v;
    if (r >= N) r = r - N;
    return W'(r);
  endfunction

  always_comb begin
    rot = '0;
    for (int i = 0; i < N; i++) begin
      rot[i] = req_i[wrap(32'(i) + 32'(ptr_i))];
    end
    found_o = |req_i;
    off = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) off = W'(i);
    end
    idx_o = wrap(32'(off) + 32'(ptr_i));
  end

endmodule

// File: rtl/fifo_drain_arbiter.sv
// Round-robin drain of NUM_SRC source FIFOs into one destination FIFO,
// up to BURST words per grant, throttled by destination almost_full.
module fifo_drain_arbiter
  import demortl_arb_pkg::*;
#(
  parameter int NUM_SRC    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int BURST      = 4,
  localparam int SRC_W     = $clog2(NUM_SRC)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_SRC-1:0]            src_enable,
  input  logic [NUM_SRC-1:0]            src_empty,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] src_dout,
  output logic [NUM_SRC-1:0]            src_rd_en,
  input  logic                          dst_almost_full,
  output logic [DATA_WIDTH-1:0]         dst_din,
  output logic                          dst_din_valid,
  output logic [SRC_W-1:0]              dst_src_id,
  output logic                          busy
);

  localparam int CNT_W = $clog2(BURST + 1);

  logic [0:0]       state_q, state_d;
  logic [SRC_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [SRC_W-1:0] grant_q, grant_d;
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
  logic             v1_q;
  logic [SRC_W-1:0] id1_q;

  logic [NUM_SRC-1:0] eligible;
  logic               pick_found;
  logic [SRC_W-1:0]   pick_idx;
  logic               issue;
  logic               last_word;
  logic [SRC_W-1:0]   grant_nxt;

  logic [DATA_WIDTH-1:0] words [NUM_SRC];

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_words
    assign words[g] = src_dout[g*DATA_WIDTH +: DATA_WIDTH];
  end

  assign eligible = src_enable & ~src_empty;

  rr_priority_pick #(
    .N (NUM_SRC),
    .W (SRC_W)
  ) u_pick (
    .req_i   (eligible),
    .ptr_i   (rr_ptr_q),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  assign issue = (state_q == READ)
               & eligible[grant_q]
               & ~dst_almost_full
               & (burst_cnt_q < CNT_W'(BURST));

  assign last_word = issue
                   & (burst_cnt_q == CNT_W'(BURST - 1));

  assign grant_nxt = (grant_q == SRC_W'(NUM_SRC - 1))
                   ? '0 : grant_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    burst_cnt_d = burst_cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d     = pick_idx;
          burst_cnt_d = '0;
          state_d     = READ;
        end
      end
      default: begin
        if (issue) burst_cnt_d = burst_cnt_q + 1'b1;
        // A stalled but still-eligible source keeps its grant.
        if (last_word || !eligible[grant_q]) begin
          state_d  = IDLE;
          rr_ptr_d = grant_nxt;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      burst_cnt_q <= '0;
      v1_q        <= 1'b0;
      id1_q       <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      burst_cnt_q <= burst_cnt_d;
      v1_q        <= issue;
      id1_q       <= grant_q;
    end
  end

  assign src_rd_en     = issue ? (NUM_SRC'(1) << grant_q) : '0;
  assign dst_din_valid = v1_q;
  assign dst_din       = v1_q ? words[id1_q] : '0;
  assign dst_src_id    = id1_q;
  assign busy          = (state_q == READ) | v1_q;

endmodule

// File: tb/tb_fifo_drain_arbiter.sv
// Bench for fifo_drain_arbiter: directed vector table, then FIFO-model
// sequences and random traffic against a per-source word scoreboard.
module tb_fifo_drain_arbiter;

  localparam int N     = 4;
  localparam int DW    = 32;
  localparam int B     = 4;
  localparam int SW    = 2;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  src_enable;
  logic [N-1:0]  src_empty;
  logic [N*DW-1:0] src_dout;
  logic [N-1:0]  src_rd_en;
  logic          dst_almost_full;
  logic [DW-1:0] dst_din;
  logic          dst_din_valid;
  logic [SW-1:0] dst_src_id;
  logic          busy;

  always #5 clk = ~clk;

  fifo_drain_arbiter #(
    .NUM_SRC    (N),
    .DATA_WIDTH (DW),
    .BURST      (B)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .src_enable      (src_enable),
    .src_empty       (src_empty),
    .src_dout        (src_dout),
    .src_rd_en       (src_rd_en),
    .dst_almost_full (dst_almost_full),
    .dst_din         (dst_din),
    .dst_din_valid   (dst_din_valid),
    .dst_src_id      (dst_src_id),
    .busy            (busy)
  );

  typedef struct {
    logic          r;
    logic [N-1:0]  en;
    logic [N-1:0]  emp;
    logic          af;
    logic [N-1:0]  rd;
    logic          v;
    logic [SW-1:0] id;
    logic          bz;
  } vec_t;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] srcq [N][$];
  logic [DW-1:0] expq [N][$];
  logic [DW-1:0] dout_r [N];
  int   dst_cnt = 0;
  int   pop_pct = 100;
  bit   af_force = 1'b0;
  bit   direct = 1'b1;
  int   cyc = 0;
  int   n_rd = 0;
  int   n_del = 0;
  int   wseq = 0;
  logic [N-1:0]  prev_rd = '0;
  logic [SW-1:0] prev_id = '0;

  int rd_src_log[$];
  int rd_cyc_log[$];
  int v_cyc_log[$];
  int run_src[$];
  int run_len[$];
  int run_first[$];
  int run_last[$];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < N; i++) begin
      srcq[i].delete();
      expq[i].delete();
      dout_r[i] = '0;
    end
    dst_cnt = 0;
    prev_rd = '0;
    prev_id = '0;
    n_rd = 0;
    n_del = 0;
  endtask

  task automatic apply();
    if (!direct) begin
      for (int i = 0; i < N; i++) begin
        src_empty[i] = (srcq[i].size() == 0);
        src_dout[i*DW +: DW] = dout_r[i];
      end
      dst_almost_full = af_force ||
        (dst_cnt + int'(dst_din_valid) >= DEPTH);
    end
    #1;
  endtask

  task automatic push(input int s, input int n);
    logic [DW-1:0] w;
    for (int k = 0; k < n; k++) begin
      w = {4'(s), 28'(wseq)};
      wseq++;
      srcq[s].push_back(w);
      expq[s].push_back(w);
    end
  endtask

  task automatic step();
    logic [N-1:0]  rd;
    logic          v;
    logic [DW-1:0] d;
    logic [SW-1:0] id;
    int            s;
    rd = src_rd_en;
    v  = dst_din_valid;
    d  = dst_din;
    id = dst_src_id;
    s  = 0;
    for (int i = 0; i < N; i++) if (rd[i]) s = i;
    if (!rst) begin
      chk("lat_valid", 64'(v), 64'(prev_rd != '0));
      if (v) begin
        chk("lat_id", 64'(id), 64'(prev_id));
        chk("dst_room", 64'(dst_cnt < DEPTH), 64'd1);
        if (expq[id].size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_word src=%0d act=%0h required=none", id, d);
        end else begin
          chk("data", 64'(d), 64'(expq[id].pop_front()));
        end
        n_del++;
        v_cyc_log.push_back(cyc);
      end
      if (rd != '0) begin
        chk("rd_onehot", 64'($onehot(rd)), 64'd1);
        chk("rd_af", 64'(dst_almost_full), 64'd0);
        chk("rd_elig", 64'(src_enable[s] & ~src_empty[s]), 64'd1);
        n_rd++;
        rd_src_log.push_back(s);
        rd_cyc_log.push_back(cyc);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (rst) begin
      clear_model();
    end else begin
      for (int i = 0; i < N; i++)
        if (rd[i] && srcq[i].size() > 0) dout_r[i] = srcq[i].pop_front();
      dst_cnt += int'(v);
      if (dst_cnt > 0 && $urandom_range(99) < pop_pct) dst_cnt--;
      prev_rd = rd;
      prev_id = SW'(s);
    end
    apply();
  endtask

  task automatic run_until_idle(input string name, input int max);
    bit done;
    done = 1'b0;
    for (int k = 0; k < max; k++) begin
      if (!busy && ((src_enable & ~src_empty) == '0)) begin
        done = 1'b1;
        break;
      end
      step();
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout act=busy required=idle", name);
    end
  endtask

  task automatic build_runs(input int base);
    int last;
    run_src.delete();
    run_len.delete();
    run_first.delete();
    run_last.delete();
    for (int k = base; k < rd_src_log.size(); k++) begin
      last = run_src.size() - 1;
      if (last >= 0 && rd_src_log[k] == run_src[last]
          && rd_cyc_log[k] == run_last[last] + 1) begin
        run_len[last] = run_len[last] + 1;
        run_last[last] = rd_cyc_log[k];
      end else begin
        run_src.push_back(rd_src_log[k]);
        run_len.push_back(1);
        run_first.push_back(rd_cyc_log[k]);
        run_last.push_back(rd_cyc_log[k]);
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    apply();
    step();
    chk("rst_valid", 64'(dst_din_valid), 64'd0);
    chk("rst_rd", 64'(src_rd_en), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_din", 64'(dst_din), 64'd0);
    chk("rst_id", 64'(dst_src_id), 64'd0);
    rst = 1'b0;
    apply();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog act=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[$];
    int   base;
    int   vbase;
    int   cnt2;
    bit   hit;

    // rst, en, emp, af | rd, v, id, busy
    tbl.push_back('{0, 4'hF, 4'hF, 0, 4'h0, 0, 0, 0});
    tbl.push_back('{0, 4'hF, 4'hB, 0, 4'h0, 0, 0, 0});
    tbl.push_back('{0, 4'hF, 4'hB, 0, 4'h4, 0, 0, 1});
    tbl.push_back('{0, 4'hF, 4'hB, 1, 4'h0, 1, 2, 1});
    tbl.push_back('{0, 4'hF, 4'hB, 0, 4'h4, 0, 0, 1});
    tbl.push_back('{0, 4'hB, 4'hB, 0, 4'h0, 1, 2, 1});
    tbl.push_back('{0, 4'hF, 4'hA, 0, 4'h0, 0, 0, 0});
    tbl.push_back('{0, 4'hF, 4'hA, 0, 4'h1, 0, 0, 1});
    tbl.push_back('{0, 4'hF, 4'hA, 0, 4'h1, 1, 0, 1});
    tbl.push_back('{0, 4'hF, 4'hA, 0, 4'h1, 1, 0, 1});
    tbl.push_back('{0, 4'hF, 4'hA, 0, 4'h1, 1, 0, 1});
    tbl.push_back('{0, 4'hF, 4'hA, 0, 4'h0, 1, 0, 1});
    tbl.push_back('{0, 4'hF, 4'hA, 0, 4'h4, 0, 0, 1});
    tbl.push_back('{0, 4'hF, 4'hF, 0, 4'h0, 1, 2, 1});
    tbl.push_back('{0, 4'hF, 4'hF, 0, 4'h0, 0, 0, 0});
    tbl.push_back('{0, 4'hF, 4'h7, 0, 4'h0, 0, 0, 0});
    tbl.push_back('{0, 4'hF, 4'h7, 0, 4'h8, 0, 0, 1});
    tbl.push_back('{1, 4'hF, 4'h7, 0, 4'h8, 1, 3, 1});
    tbl.push_back('{0, 4'h0, 4'hF, 0, 4'h0, 0, 0, 0});

    direct = 1'b1;
    rst = 1'b1;
    src_enable = '0;
    src_empty = '1;
    dst_almost_full = 1'b0;
    for (int i = 0; i < N; i++) src_dout[i*DW +: DW] = 32'hD000_0000 | i;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("init_valid", 64'(dst_din_valid), 64'd0);
    chk("init_rd", 64'(src_rd_en), 64'd0);
    chk("init_busy", 64'(busy), 64'd0);

    foreach (tbl[r]) begin
      rst = tbl[r].r;
      src_enable = tbl[r].en;
      src_empty = tbl[r].emp;
      dst_almost_full = tbl[r].af;
      #1;
      chk($sformatf("vec%0d_rd", r), 64'(src_rd_en), 64'(tbl[r].rd));
      chk($sformatf("vec%0d_v", r), 64'(dst_din_valid), 64'(tbl[r].v));
      chk($sformatf("vec%0d_busy", r), 64'(busy), 64'(tbl[r].bz));
      if (tbl[r].v) begin
        chk($sformatf("vec%0d_id", r), 64'(dst_src_id), 64'(tbl[r].id));
        chk($sformatf("vec%0d_din", r), 64'(dst_din),
            64'(32'hD000_0000 | 32'(tbl[r].id)));
      end
      @(posedge clk);
      #1;
    end

    // single source, three words
    direct = 1'b0;
    clear_model();
    src_enable = '1;
    pop_pct = 100;
    do_reset();
    push(0, 3);
    apply();
    cyc = 1;
    base = rd_src_log.size();
    vbase = v_cyc_log.size();
    run_until_idle("t1", 30);
    build_runs(base);
    chk("t1_runs", 64'(run_src.size()), 64'd1);
    if (run_src.size() > 0) begin
      chk("t1_src", 64'(run_src[0]), 64'd0);
      chk("t1_first_rd", 64'(run_first[0]), 64'd2);
      chk("t1_len", 64'(run_len[0]), 64'd3);
    end
    chk("t1_nv", 64'(v_cyc_log.size() - vbase), 64'd3);
    if (v_cyc_log.size() - vbase == 3) begin
      chk("t1_v0", 64'(v_cyc_log[vbase]), 64'd3);
      chk("t1_v2", 64'(v_cyc_log[vbase+2]), 64'd5);
    end
    base = rd_src_log.size();
    push(0, 1);
    push(1, 1);
    apply();
    run_until_idle("t1b", 30);
    build_runs(base);
    if (run_src.size() > 0) chk("t1_ptr_next", 64'(run_src[0]), 64'd1);
    else chk("t1_ptr_runs", 64'(run_src.size()), 64'd2);

    // all sources loaded, no backpressure
    do_reset();
    for (int s = 0; s < N; s++) push(s, 8);
    apply();
    base = rd_src_log.size();
    run_until_idle("t2", 200);
    build_runs(base);
    chk("t2_runs", 64'(run_src.size()), 64'd8);
    for (int k = 0; k < run_src.size() && k < 8; k++) begin
      chk($sformatf("t2_src%0d", k), 64'(run_src[k]), 64'(k % N));
      chk($sformatf("t2_len%0d", k), 64'(run_len[k]), 64'(B));
      if (k > 0)
        chk($sformatf("t2_gap%0d", k),
            64'(run_first[k] - run_last[k-1]), 64'd2);
    end
    chk("t2_total", 64'(rd_src_log.size() - base), 64'd32);
    chk("t2_delivered", 64'(n_del), 64'(n_rd));

    // backpressure after two words
    push(0, 4);
    apply();
    base = rd_src_log.size();
    hit = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (rd_src_log.size() - base == 2) begin
        hit = 1'b1;
        break;
      end
      step();
    end
    chk("t3_two_words", 64'(hit), 64'd1);
    af_force = 1'b1;
    apply();
    for (int k = 0; k < 5; k++) begin
      chk("t3_stall_rd", 64'(src_rd_en), 64'd0);
      step();
      chk("t3_stall_busy", 64'(busy), 64'd1);
    end
    af_force = 1'b0;
    apply();
    chk("t3_resume_rd", 64'(src_rd_en), 64'd1);
    run_until_idle("t3", 40);
    chk("t3_total", 64'(rd_src_log.size() - base), 64'd4);
    chk("t3_delivered", 64'(n_del), 64'(n_rd));

    // masking, then enable drop mid-burst
    src_enable = 4'b0101;
    for (int s = 0; s < N; s++) push(s, 8);
    apply();
    base = rd_src_log.size();
    hit = 1'b0;
    for (int k = 0; k < 80; k++) begin
      cnt2 = 0;
      for (int j = base; j < rd_src_log.size(); j++)
        if (rd_src_log[j] == 2) cnt2++;
      if (cnt2 == 6) begin
        hit = 1'b1;
        break;
      end
      step();
    end
    chk("t4_reached", 64'(hit), 64'd1);
    src_enable = 4'b0001;
    apply();
    chk("t4_drop_rd", 64'(src_rd_en), 64'd0);
    run_until_idle("t4", 60);
    build_runs(base);
    chk("t4_runs", 64'(run_src.size()), 64'd4);
    if (run_src.size() == 4) begin
      chk("t4_r0", 64'(run_src[0]), 64'd2);
      chk("t4_r1", 64'(run_src[1]), 64'd0);
      chk("t4_r2", 64'(run_src[2]), 64'd2);
      chk("t4_r3", 64'(run_src[3]), 64'd0);
      chk("t4_l2", 64'(run_len[2]), 64'd2);
      chk("t4_l3", 64'(run_len[3]), 64'd4);
    end
    chk("t4_delivered", 64'(n_del), 64'(n_rd));

    // reset with a word in flight
    src_enable = 4'b0100;
    apply();
    run_until_idle("t5a", 30);
    push(2, 4);
    apply();
    hit = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (dst_din_valid) begin
        hit = 1'b1;
        break;
      end
      step();
    end
    chk("t5_inflight", 64'(hit), 64'd1);
    chk("t5_busy_pre", 64'(busy), 64'd1);
    do_reset();
    src_enable = '1;
    push(1, 2);
    push(3, 2);
    apply();
    base = rd_src_log.size();
    run_until_idle("t5", 40);
    build_runs(base);
    chk("t5_runs", 64'(run_src.size()), 64'd2);
    if (run_src.size() == 2) begin
      chk("t5_first", 64'(run_src[0]), 64'd1);
      chk("t5_second", 64'(run_src[1]), 64'd3);
    end

    // wrap from rr_ptr=3
    push(2, 1);
    apply();
    run_until_idle("t6a", 20);
    base = rd_src_log.size();
    push(3, 2);
    push(0, 2);
    apply();
    run_until_idle("t6b", 30);
    build_runs(base);
    chk("t6_runs", 64'(run_src.size()), 64'd2);
    if (run_src.size() == 2) begin
      chk("t6_first", 64'(run_src[0]), 64'd3);
      chk("t6_second", 64'(run_src[1]), 64'd0);
    end
    base = rd_src_log.size();
    push(0, 1);
    push(1, 1);
    apply();
    run_until_idle("t6c", 20);
    build_runs(base);
    if (run_src.size() > 0) chk("t6_ptr_wrap", 64'(run_src[0]), 64'd1);
    else chk("t6_ptr_runs", 64'(run_src.size()), 64'd2);

    // random traffic with random enables and destination drain rate
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(7) == 0) src_enable = N'($urandom);
      if ($urandom_range(31) == 0) pop_pct = $urandom_range(20, 100);
      if ($urandom_range(2) == 0) begin
        int s;
        s = $urandom_range(N - 1);
        if (srcq[s].size() < 12) push(s, $urandom_range(1, 3));
      end
      apply();
      step();
    end
    src_enable = '1;
    pop_pct = 100;
    apply();
    run_until_idle("rand_drain", 2000);
    chk("rand_delivered", 64'(n_del), 64'(n_rd));
    for (int s = 0; s < N; s++)
      chk($sformatf("rand_left%0d", s), 64'(expq[s].size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
